// File: rtl/spi_slave_responder.sv
// SPI mode-0 target: synchronized sck/cs/mosi, FWFT RX FIFO, single-entry TX holding register.
// Optional per-frame byte counter output frame_bytes enabled by `define SPI_SLV_FRAME_CNT_EN.
module spi_slave_responder #(
  parameter int         RX_DEPTH    = 4,
  parameter logic [7:0] FILL_BYTE   = 8'hFF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic       spi_sck,
  input  logic       spi_cs,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic [7:0] tx_din,
  input  logic       tx_wr,
  output logic       tx_full,
  output logic [7:0] rx_dout,
  input  logic       rx_rd,
  output logic       rx_data_avail,
  output logic       rx_overrun,
  input  logic       rx_overrun_clr,
  output logic       busy
`ifdef SPI_SLV_FRAME_CNT_EN
  ,
  output logic [7:0] frame_bytes
`endif
);

  localparam int AW = $clog2(RX_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RX_DEPTH);

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic [SYNC_STAGES:0]   flush_q;
  logic sck_h_q, cs_h_q, armed_q;
  logic sck_s, cs_s, mosi_s;
  logic sck_rise, sck_fall, cs_fall, cs_rise;

  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          byte_done_q, byte_done_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic [7:0]    hold_q, hold_d;
  logic          tx_full_q, tx_full_d;
  logic          load, push;
  logic [7:0]    push_byte;

  logic [7:0]    mem_q [RX_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovr_q, ovr_d;
  logic          pop, fifo_full, wr_en;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // A cs fall only counts once cs has been seen high after the chains flushed,
  // so a cs already low at reset release cannot start a frame.
  assign sck_rise = sck_s & ~sck_h_q;
  assign sck_fall = ~sck_s & sck_h_q;
  assign cs_fall  = cs_h_q & ~cs_s & armed_q;
  assign cs_rise  = ~cs_h_q & cs_s;

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      flush_q     <= '0;
      sck_h_q     <= 1'b0;
      cs_h_q      <= 1'b1;
      armed_q     <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      flush_q     <= {flush_q[SYNC_STAGES-1:0], 1'b1};
      sck_h_q     <= sck_s;
      cs_h_q      <= cs_s;
      armed_q     <= armed_q | (flush_q[SYNC_STAGES] & cs_s);
    end
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall) state_d = ACTIVE;
      ACTIVE:  if (cs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q == ACTIVE);
    spi_miso_oe = busy;
    spi_miso    = busy & tx_shift_q[7];
  end

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    byte_done_d = byte_done_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    load        = 1'b0;
    push        = 1'b0;
    push_byte   = {rx_shift_q[6:0], mosi_s};
    if (state_q == IDLE) begin
      if (cs_fall) begin
        load        = 1'b1;
        bit_cnt_d   = 3'd0;
        byte_done_d = 1'b0;
      end
    end else if (cs_rise) begin
      bit_cnt_d   = 3'd0;
      byte_done_d = 1'b0;
    end else if (sck_rise) begin
      rx_shift_d = push_byte;
      bit_cnt_d  = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        push        = 1'b1;
        byte_done_d = 1'b1;
      end
    end else if (sck_fall) begin
      if (byte_done_q) begin
        load        = 1'b1;
        byte_done_d = 1'b0;
      end else if (bit_cnt_q != 3'd0) begin
        tx_shift_d = {tx_shift_q[6:0], 1'b0};
      end
    end
    if (load) tx_shift_d = tx_full_q ? hold_q : FILL_BYTE;
  end

  // A write landing in the same cycle as a load from an empty holding register
  // is kept for the following byte.
  always_comb begin
    tx_full_d = tx_full_q;
    hold_d    = hold_q;
    if (load) tx_full_d = 1'b0;
    if (tx_wr && !tx_full_q) begin
      tx_full_d = 1'b1;
      hold_d    = tx_din;
    end
  end

  assign pop       = rx_rd & (cnt_q != '0);
  assign fifo_full = (cnt_q == DEPTH_C);
  assign wr_en     = push & (~fifo_full | pop);

  always_comb begin
    cnt_d = cnt_q;
    if (wr_en && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!wr_en && pop) cnt_d = cnt_q - CW'(1);
    ovr_d = ovr_q;
    if (push && fifo_full && !pop) ovr_d = 1'b1;
    else if (rx_overrun_clr)       ovr_d = 1'b0;
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      bit_cnt_q   <= 3'd0;
      byte_done_q <= 1'b0;
      rx_shift_q  <= 8'h00;
      tx_shift_q  <= 8'h00;
      hold_q      <= 8'h00;
      tx_full_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      ovr_q       <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      byte_done_q <= byte_done_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      hold_q      <= hold_d;
      tx_full_q   <= tx_full_d;
      cnt_q       <= cnt_d;
      ovr_q       <= ovr_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_byte;
  end

  assign tx_full       = tx_full_q;
  assign rx_data_avail = (cnt_q != '0);
  assign rx_dout       = rx_data_avail ? mem_q[rd_ptr_q] : 8'h00;
  assign rx_overrun    = ovr_q;

`ifdef SPI_SLV_FRAME_CNT_EN
  logic [7:0] frame_q;
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst)                            frame_q <= 8'h00;
    else if (state_q == IDLE && cs_fall) frame_q <= 8'h00;
    else if (push && frame_q != 8'hFF)   frame_q <= frame_q + 8'd1;
  end
  assign frame_bytes = frame_q;
`endif

endmodule

// File: tb/tb_spi_slave_responder.sv
// Scoreboard bench for spi_slave_responder: a behavioural SPI master drives frames,
// expected miso/RX bytes are queued at stimulus time and checked on readback.
module tb_spi_slave_responder;
  localparam int S    = 2;
  localparam int HALF = 8;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       Rst, spi_sck, spi_cs, spi_mosi, spi_miso, spi_miso_oe;
  logic [7:0] tx_din, rx_dout;
  logic       tx_wr, tx_full, rx_rd, rx_data_avail, rx_overrun, rx_overrun_clr, busy;
`ifdef SPI_SLV_FRAME_CNT_EN
  logic [7:0] frame_bytes;
`endif

  spi_slave_responder #(.RX_DEPTH(4), .FILL_BYTE(8'hFF), .SYNC_STAGES(S)) dut (
    .clk(clk), .Rst(Rst), .spi_sck(spi_sck), .spi_cs(spi_cs), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .tx_din(tx_din), .tx_wr(tx_wr),
    .tx_full(tx_full), .rx_dout(rx_dout), .rx_rd(rx_rd), .rx_data_avail(rx_data_avail),
    .rx_overrun(rx_overrun), .rx_overrun_clr(rx_overrun_clr), .busy(busy)
`ifdef SPI_SLV_FRAME_CNT_EN
    , .frame_bytes(frame_bytes)
`endif
  );

  int checks = 0, failures = 0;
  logic [7:0] rx_q[$], tx_q[$];
  logic [7:0] mo[8], mi[8];
  bit         mid_wr = 0, rd_hook = 0, lat_arm = 0;
  logic [7:0] mid_byte, rd_val;
  int         lat;

  task automatic pulse_rd();
    rx_rd = 1'b1; @(negedge clk); rx_rd = 1'b0;
  endtask

  task automatic write_tx(input logic [7:0] d);
    tx_din = d; tx_wr = 1'b1; @(negedge clk); tx_wr = 1'b0;
  endtask

  // Mode-0 master: mosi changes while sck low, miso sampled at sck rise.
  task automatic spi_frame(input int n);
    spi_cs = 1'b0;
    for (int b = 0; b < n; b++) begin
      for (int i = 7; i >= 0; i--) begin
        spi_mosi = mo[b][i];
        repeat (HALF) @(negedge clk);
        spi_sck = 1'b1;
        mi[b][i] = spi_miso;
        for (int c = 0; c < HALF; c++) begin
          @(negedge clk);
          if (lat_arm && b == 0 && i == 0 && rx_data_avail && lat < 0) lat = c + 1;
          if (mid_wr && b == 0 && i == 4) begin
            if (c == 0) begin tx_din = mid_byte; tx_wr = 1'b1; end
            else tx_wr = 1'b0;
          end
          if (rd_hook && b == n - 1 && i == 0) begin
            if (c == S - 1) begin rd_val = rx_dout; rx_rd = 1'b1; end
            else if (c == S) rx_rd = 1'b0;
          end
        end
        spi_sck = 1'b0;
      end
    end
    repeat (HALF) @(negedge clk);
    spi_cs = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic test_reset();
    Rst = 1'b0; spi_sck = 1'b0; spi_cs = 1'b1; spi_mosi = 1'b0;
    tx_din = 8'h00; tx_wr = 1'b0; rx_rd = 1'b0; rx_overrun_clr = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({spi_miso, spi_miso_oe, tx_full, rx_data_avail, rx_overrun, busy} !== 6'b0 || rx_dout !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs: got miso=%b oe=%b full=%b avail=%b ovr=%b busy=%b dout=%h, want all 0",
               spi_miso, spi_miso_oe, tx_full, rx_data_avail, rx_overrun, busy, rx_dout);
    end
    Rst = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_single();
    logic [7:0] exp;
    mo[0] = 8'hA5; tx_q.push_back(8'hFF); rx_q.push_back(8'hA5);
    lat = -1; lat_arm = 1;
    spi_frame(1);
    lat_arm = 0;
    exp = tx_q.pop_front(); checks++;
    if (mi[0] !== exp) begin failures++; $display("FAIL single_miso: got %h want %h", mi[0], exp); end
    checks++;
    if (lat < 1 || lat > S + 2) begin failures++; $display("FAIL single_latency: got %0d want 1..%0d", lat, S + 2); end
    while (rx_q.size() > 0) begin
      exp = rx_q.pop_front(); checks++;
      if (rx_data_avail !== 1'b1 || rx_dout !== exp) begin
        failures++; $display("FAIL single_rx: got avail=%b dout=%h want 1/%h", rx_data_avail, rx_dout, exp);
      end
      pulse_rd();
    end
    checks++;
    if (rx_data_avail !== 1'b0) begin failures++; $display("FAIL single_empty: got %b want 0", rx_data_avail); end
  endtask

  task automatic test_reply();
    logic [7:0] exp;
    write_tx(8'h3C);
    checks++;
    if (tx_full !== 1'b1) begin failures++; $display("FAIL reply_full: got %b want 1", tx_full); end
    write_tx(8'h99);
    mo[0] = 8'h00; tx_q.push_back(8'h3C); rx_q.push_back(8'h00);
    spi_frame(1);
    exp = tx_q.pop_front(); checks++;
    if (mi[0] !== exp) begin failures++; $display("FAIL reply_miso: got %h want %h", mi[0], exp); end
    checks++;
    if (tx_full !== 1'b0) begin failures++; $display("FAIL reply_consumed: got %b want 0", tx_full); end
    while (rx_q.size() > 0) begin
      exp = rx_q.pop_front(); checks++;
      if (rx_data_avail !== 1'b1 || rx_dout !== exp) begin
        failures++; $display("FAIL reply_rx: got avail=%b dout=%h want 1/%h", rx_data_avail, rx_dout, exp);
      end
      pulse_rd();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    write_tx(8'h11);
    mo[0] = 8'h01; mo[1] = 8'h02; mo[2] = 8'h03;
    tx_q.push_back(8'h11); tx_q.push_back(8'h22); tx_q.push_back(8'hFF);
    rx_q.push_back(8'h01); rx_q.push_back(8'h02); rx_q.push_back(8'h03);
    mid_wr = 1; mid_byte = 8'h22;
    spi_frame(3);
    mid_wr = 0;
    for (int b = 0; b < 3; b++) begin
      exp = tx_q.pop_front(); checks++;
      if (mi[b] !== exp) begin failures++; $display("FAIL b2b_miso%0d: got %h want %h", b, mi[b], exp); end
    end
`ifdef SPI_SLV_FRAME_CNT_EN
    checks++;
    if (frame_bytes !== 8'd3) begin failures++; $display("FAIL frame_cnt_held: got %0d want 3", frame_bytes); end
    spi_cs = 1'b0; repeat (HALF) @(negedge clk);
    checks++;
    if (frame_bytes !== 8'd0) begin failures++; $display("FAIL frame_cnt_clear: got %0d want 0", frame_bytes); end
    spi_cs = 1'b1; repeat (HALF) @(negedge clk);
`endif
    while (rx_q.size() > 0) begin
      exp = rx_q.pop_front(); checks++;
      if (rx_data_avail !== 1'b1 || rx_dout !== exp) begin
        failures++; $display("FAIL b2b_rx: got avail=%b dout=%h want 1/%h", rx_data_avail, rx_dout, exp);
      end
      pulse_rd();
    end
  endtask

  task automatic test_overrun();
    logic [7:0] exp;
    for (int b = 0; b < 5; b++) begin
      mo[b] = 8'(8'h10 * (b + 1));
      tx_q.push_back(8'hFF);
      if (b < 4) rx_q.push_back(mo[b]);
    end
    spi_frame(5);
    for (int b = 0; b < 5; b++) begin
      exp = tx_q.pop_front(); checks++;
      if (mi[b] !== exp) begin failures++; $display("FAIL ovr_miso%0d: got %h want %h", b, mi[b], exp); end
    end
    checks++;
    if (rx_overrun !== 1'b1) begin failures++; $display("FAIL ovr_set: got %b want 1", rx_overrun); end
    rx_overrun_clr = 1'b1; @(negedge clk); rx_overrun_clr = 1'b0;
    checks++;
    if (rx_overrun !== 1'b0) begin failures++; $display("FAIL ovr_clr: got %b want 0", rx_overrun); end
    mo[0] = 8'h60; tx_q.push_back(8'hFF);
    rd_hook = 1;
    spi_frame(1);
    rd_hook = 0;
    exp = rx_q.pop_front(); checks++;
    if (rd_val !== exp) begin failures++; $display("FAIL ovr_same_cycle_rd: got %h want %h", rd_val, exp); end
    rx_q.push_back(8'h60);
    exp = tx_q.pop_front(); checks++;
    if (mi[0] !== exp) begin failures++; $display("FAIL ovr_miso_last: got %h want %h", mi[0], exp); end
    checks++;
    if (rx_overrun !== 1'b0) begin failures++; $display("FAIL ovr_none_on_rd: got %b want 0", rx_overrun); end
    while (rx_q.size() > 0) begin
      exp = rx_q.pop_front(); checks++;
      if (rx_data_avail !== 1'b1 || rx_dout !== exp) begin
        failures++; $display("FAIL ovr_rx: got avail=%b dout=%h want 1/%h", rx_data_avail, rx_dout, exp);
      end
      pulse_rd();
    end
    checks++;
    if (rx_data_avail !== 1'b0) begin failures++; $display("FAIL ovr_drained: got %b want 0", rx_data_avail); end
  endtask

  task automatic test_abort();
    logic [7:0] exp, pat;
    pat = 8'hF0;
    spi_cs = 1'b0;
    for (int i = 7; i >= 3; i--) begin
      spi_mosi = pat[i];
      repeat (HALF) @(negedge clk); spi_sck = 1'b1;
      repeat (HALF) @(negedge clk); spi_sck = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    spi_cs = 1'b1;
    repeat (HALF) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || spi_miso_oe !== 1'b0 || spi_miso !== 1'b0) begin
      failures++; $display("FAIL abort_idle: got busy=%b oe=%b miso=%b want 0", busy, spi_miso_oe, spi_miso);
    end
    checks++;
    if (rx_data_avail !== 1'b0) begin failures++; $display("FAIL abort_no_push: got %b want 0", rx_data_avail); end
    write_tx(8'hC3);
    mo[0] = 8'h5A; tx_q.push_back(8'hC3); rx_q.push_back(8'h5A);
    spi_frame(1);
    exp = tx_q.pop_front(); checks++;
    if (mi[0] !== exp) begin failures++; $display("FAIL abort_next_miso: got %h want %h", mi[0], exp); end
    while (rx_q.size() > 0) begin
      exp = rx_q.pop_front(); checks++;
      if (rx_data_avail !== 1'b1 || rx_dout !== exp) begin
        failures++; $display("FAIL abort_next_rx: got avail=%b dout=%h want 1/%h", rx_data_avail, rx_dout, exp);
      end
      pulse_rd();
    end
  endtask

  task automatic test_reset_midframe();
    spi_cs = 1'b0;
    repeat (HALF) @(negedge clk);
    write_tx(8'h77);
    spi_mosi = 1'b1;
    repeat (HALF) @(negedge clk); spi_sck = 1'b1;
    repeat (HALF) @(negedge clk); spi_sck = 1'b0;
    checks++;
    if (busy !== 1'b1 || tx_full !== 1'b1) begin
      failures++; $display("FAIL midrst_pre: got busy=%b full=%b want 1/1", busy, tx_full);
    end
    #3 Rst = 1'b0;
    #1;
    checks++;
    if ({spi_miso, spi_miso_oe, tx_full, rx_data_avail, rx_overrun, busy} !== 6'b0 || rx_dout !== 8'h00) begin
      failures++; $display("FAIL midrst_async: got miso=%b oe=%b full=%b avail=%b ovr=%b busy=%b",
                           spi_miso, spi_miso_oe, tx_full, rx_data_avail, rx_overrun, busy);
    end
`ifdef SPI_SLV_FRAME_CNT_EN
    checks++;
    if (frame_bytes !== 8'd0) begin failures++; $display("FAIL midrst_frame_cnt: got %0d want 0", frame_bytes); end
`endif
    @(negedge clk); Rst = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL midrst_cs_low_ignored: got busy=%b want 0", busy); end
    spi_cs = 1'b1; repeat (HALF) @(negedge clk);
    spi_cs = 1'b0; repeat (HALF) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || spi_miso !== 1'b1) begin
      failures++; $display("FAIL midrst_fresh_frame: got busy=%b miso=%b want 1/1", busy, spi_miso);
    end
    spi_cs = 1'b1; repeat (HALF) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_reply();
    test_back_to_back();
    test_overrun();
    test_abort();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/spi_slave_responder.md
Name: spi_slave_responder

Overview:
- Target-side (slave) end of the SPI link driven by spi_controller: responds to an external SPI master on sck/cs/mosi/miso.
- SPI mode 0 (CPOL=0, CPHA=0), 8-bit bytes, MSB first.
- Received bytes go into a small first-word-fall-through RX FIFO. Reply bytes come from a single-entry TX holding register. Both are exposed as an MMIO-style port on the 50 MHz core clock.
- All SPI pins are asynchronous to clk and are synchronized internally.

Parameters:
RX_DEPTH, 4, RX FIFO entries (power of 2, >=2)
FILL_BYTE, 8'hFF, byte shifted out when TX holding register is empty at byte start
SYNC_STAGES, 2, flip-flop stages on sck/cs/mosi (>=2)

Ports:
clk  input  1  core clock (clk_50M domain)
Rst  input  1  asynchronous, active-low reset
spi_sck  input  1  SPI clock from master; max frequency clk/8
spi_cs  input  1  chip select, active-low
spi_mosi  input  1  master-out data
spi_miso  output  1  slave-out data
spi_miso_oe  output  1  tri-state enable for miso; 1 while cs asserted
tx_din  input  8  reply byte
tx_wr  input  1  write tx_din into TX holding register (1-cycle strobe)
tx_full  output  1  TX holding register occupied
rx_dout  input/output: output  8  head of RX FIFO (valid when rx_data_avail)
rx_rd  input  1  pop RX FIFO head
rx_data_avail  output  1  RX FIFO not empty
rx_overrun  output  1  sticky: byte dropped because RX FIFO was full
rx_overrun_clr  input  1  clears rx_overrun
busy  output  1  cs asserted (synchronized)

Behaviour:
- Reset (Rst=0, asynchronous): all outputs 0; FIFO empty; TX holding empty; bit counter 0; sync chains loaded idle (sck=0, cs=1).
- Sync and edge detect: SYNC_STAGES flops per pin, plus one history flop for edge detection. Edges act 1 clk after the last sync stage; total latency from pin to action is SYNC_STAGES+1 clk.
- States: IDLE, ACTIVE.
- IDLE -> ACTIVE on synchronized cs fall:
  - busy=1 and spi_miso_oe=1.
  - Shift-out register loads the TX holding byte if tx_full, otherwise FILL_BYTE. tx_full clears on the same edge.
  - spi_miso = bit 7; bit_cnt=0.
- ACTIVE, synchronized sck rise: shift spi_mosi into rx_shift LSB; bit_cnt++.
- On the 8th rise (bit_cnt 7->0): the byte completes and is pushed to the FIFO. rx_data_avail rises on the next clk.
- ACTIVE, synchronized sck fall:
  - If the fall follows bit 1..7: shift out the next bit.
  - If it follows the 8th rise: load the next byte (holding or FILL_BYTE) and drive its bit 7. This is a back-to-back byte in the same frame.
- ACTIVE -> IDLE on synchronized cs rise, any bit_cnt:
  - A partial RX byte is discarded, not pushed.
  - The already-loaded TX byte is consumed and not restored.
  - bit_cnt=0, busy=0, spi_miso_oe=0, spi_miso=0.
- sck edges while in IDLE are ignored.
- RX FIFO:
  - Full and push without rx_rd in the same cycle: byte dropped, rx_overrun<=1.
  - Full with push and rx_rd in the same cycle: both accepted.
  - rx_rd when empty: ignored.
  - Pointers wrap modulo RX_DEPTH; count width is clog2(RX_DEPTH)+1.
- rx_overrun: set has priority over rx_overrun_clr in the same cycle.
- TX holding register:
  - tx_wr while tx_full: ignored, no overwrite.
  - tx_wr in the same cycle as a load while empty: the load takes FILL_BYTE and the write lands in holding (tx_full=1) for the next byte.
- Reset asserted mid-frame: immediate return to reset state. After release, the responder waits for a fresh cs fall; if cs is already low at release, nothing happens until cs rises and falls again.

Optional Feature:
- Macro SPI_SLV_FRAME_CNT_EN.
- Defined:
  - Adds output frame_bytes[7:0]: count of complete bytes received in the current cs frame.
  - Cleared on cs fall; incremented on each 8th sck rise, saturating at 8'hFF; held after cs rise until the next cs fall.
  - Reset value 0.
- Undefined: port absent, no counter logic.

Test Plan:
- Reset release, single frame: holding empty, master sends 8'hA5 -> master reads 8'hFF on miso; rx_dout=8'hA5 with rx_data_avail=1 within SYNC_STAGES+2 clk of the 8th sck rise; one rx_rd -> rx_data_avail=0.
- Reply path: tx_wr with 8'h3C, then frame sending 8'h00 -> master reads 8'h3C; tx_full drops at cs fall; FIFO holds 8'h00.
- Back-to-back bytes: tx 8'h11 preloaded; 3-byte frame 8'h01,8'h02,8'h03; second tx_wr 8'h22 issued mid-byte-1 -> master reads 11,22,FF; FIFO 01,02,03 in order.
- Overrun: RX_DEPTH=4, 5 bytes sent with no rx_rd -> first 4 retained, 5th dropped, rx_overrun=1; rx_overrun_clr -> 0; a push and rx_rd in the same cycle when full -> no overrun.
- Abort: cs rises after 5 sck edges of 8'hF0 -> no push, busy=0, next frame starts at bit 7 and returns the byte correctly.
- With SPI_SLV_FRAME_CNT_EN defined: frame_bytes reads 3 after a 3-byte frame and 0 after the next cs fall; async Rst pulse mid-frame -> all outputs 0 immediately.
